tick_binned_axon_queue: RTL and testbench
=========================================

# tick_binned_axon_queue

Tick-aware successor to the core's axon-spike input FIFO and completion counters, sitting between the router's local output and the controller. Incoming spike packets carry a delivery-tick offset. Each packet is binned into one of NUM_TICKS ring banks and released to the controller only while its delivery tick is the current tick. The block also tracks outstanding synapse work and produces the core-done indication for the current tick.

## Interface
Parameters:
- NUM_AXONS, 256: axon count; AXON_W = $clog2(NUM_AXONS).
- NUM_TICKS, 16: tick bins; power of two; TICK_W = $clog2(NUM_TICKS).
- BANK_DEPTH, 8: entries per bin; power of two.
- OUTSTANDING_MAX, 4: maximum spikes read but not yet acknowledged.

Ports (reset is asynchronous and active-high):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  packet write strobe (router dout_wen_local).
- wr_packet  in  AXON_W+TICK_W  {axon[AXON_W-1:0], tick_offset[TICK_W-1:0]}; axon occupies the MSBs.
- full  out  1  combinational; the bank addressed by the current wr_packet is full.
- tick  in  1  single-cycle pulse that advances cur_tick.
- rd_en  in  1  read request from the controller.
- rd_axon  out  AXON_W  axon number; reset 0.
- rd_valid  out  1  rd_axon valid, one-cycle pulse; reset 0.
- empty  out  1  current bank empty; reset 1.
- proc_done  in  1  pulse from synapse_connection: one spike fully processed.
- core_done  out  1  current tick fully drained; reset 1.
- cur_tick  out  TICK_W  current tick index; reset 0.
- error  out  3  sticky {underflow, late, overflow}; reset 0; cleared only by rst.

## Operation
- Write target bank = (cur_tick + tick_offset) mod NUM_TICKS, computed with the pre-edge cur_tick.
- wr_en while the target bank is full: the packet is dropped and error[0] (overflow) is set.
- Read: rd_en with !empty and no tick in the same cycle pops the head of bank cur_tick. rd_axon/rd_valid are driven the following cycle. rd_en while empty is ignored with no error.
- Outstanding counter (0..OUTSTANDING_MAX):
  - +1 on an accepted read; −1 on proc_done; unchanged when both occur in the same cycle.
  - proc_done with counter 0 sets error[2] (underflow); the counter stays 0.
  - An accepted read is refused (treated as ignored) when the counter equals OUTSTANDING_MAX.
- Tick:
  - cur_tick increments modulo NUM_TICKS.
  - If the old bank is non-empty or the outstanding counter is non-zero, error[1] (late) is set. The old bank is flushed (pointers and count zeroed) and the outstanding counter is cleared.
  - A write in the tick cycle whose target equals the old bank (offset 0) is dropped and sets error[1].
- Completion FSM:
  - IDLE: bank empty and outstanding = 0. core_done = 1.
  - SERVE: bank non-empty.
  - DRAIN: bank empty and outstanding > 0.
  - Transitions: IDLE→SERVE on a write into the current bank; SERVE→DRAIN when the last entry is read; DRAIN→IDLE when the counter reaches 0; DRAIN→SERVE on a write into the current bank; any state→IDLE on tick, then →SERVE next cycle if the new bank is non-empty.
- Bank count width = $clog2(BANK_DEPTH)+1. Pointer wrap is natural modulo BANK_DEPTH.

## Timing
- Write→empty deasserts: 1 cycle (registered counts).
- rd_en→rd_valid: 1 cycle. Back-to-back reads sustain 1 entry per cycle.
- Tick→new cur_tick visible: 1 cycle. empty and core_done reflect the new bank in that same cycle.
- Simultaneous write and read on the same bank: both are honoured; count is unchanged. A full bank accepts the write only if a read pops in the same cycle.
- Asserting rst mid-operation clears all banks, counters, the FSM and error immediately. Outputs return to their reset values asynchronously.

## Configuration
- AXQ_STATS_EN defined: adds outputs drop_full_cnt and drop_late_cnt (16 bits each, saturating, reset 0). These count overflow drops, and late flushed entries plus late writes.
- Undefined: the ports and counters are absent. The error bits are unaffected.

## Structure
- Package axq_pkg: AXON_W/TICK_W derivation functions, FSM state enum {IDLE, SERVE, DRAIN}, and error bit index constants.
- Sub-module tick_bank_ring: per-bank rd/wr pointers and count, with push/pop/flush inputs and full/empty outputs. It is instantiated NUM_TICKS times via generate.
- Storage: one NUM_TICKS*BANK_DEPTH × AXON_W array, one write port and one registered read port, addressed {bank, ptr}.

## Test plan
Use NUM_TICKS=16, BANK_DEPTH=8.
- Write axon 0x2A with offset 0, then rd_en → rd_axon=0x2A and rd_valid one cycle later. After proc_done, core_done=1 and the FSM is IDLE.
- Write axon 5 with offset 3, with cur_tick=0 → empty stays 1 for ticks 0–2. After the third tick pulse, cur_tick=3, empty=0, and the read returns 5.
- Write 9 packets with offset 2 → the 9th is dropped and error[0]=1. After two ticks, exactly 8 reads return data in write order.
- cur_tick=15, write with offset 2 → delivered at cur_tick=1 (wrap).
- Read one spike, withhold proc_done, then pulse tick → error[1]=1, outstanding cleared, core_done=1.
- proc_done with nothing outstanding → error[2]=1. Under AXQ_STATS_EN, the overflow scenario yields drop_full_cnt=1.

Source files
------------

// File: rtl/axq_pkg.sv
// Shared types and helpers for the tick-binned axon queue.
package axq_pkg;

  // Completion tracking for the current tick.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2
  } axq_state_e;

  // Bit positions inside the sticky error vector.
  localparam int ERR_OVF  = 0;
  localparam int ERR_LATE = 1;
  localparam int ERR_UNF  = 2;

  // Index widths; keep at least one bit so degenerate configs still elaborate.
  function automatic int axon_width(input int num_axons);
    return (num_axons > 1) ? $clog2(num_axons) : 1;
  endfunction

  function automatic int tick_width(input int num_ticks);
    return (num_ticks > 1) ? $clog2(num_ticks) : 1;
  endfunction

endpackage

// File: rtl/tick_bank_ring.sv
// Pointer/occupancy tracking for one tick bin. Storage lives in the parent.
module tick_bank_ring
  import axq_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  // Flush wins over push/pop; simultaneous push+pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/tick_binned_axon_queue.sv
// Tick-binned axon spike queue with outstanding-work tracking and core-done.
// Optional build macro AXQ_STATS_EN adds saturating drop counters.
module tick_binned_axon_queue
  import axq_pkg::*;
#(
  parameter  int NUM_AXONS       = 256,
  parameter  int NUM_TICKS       = 16,
  parameter  int BANK_DEPTH      = 8,
  parameter  int OUTSTANDING_MAX = 4,
  localparam int AXON_W          = axon_width(NUM_AXONS),
  localparam int TICK_W          = tick_width(NUM_TICKS)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AXON_W+TICK_W-1:0] wr_packet,
  output logic                     full,
  input  logic                     tick,
  input  logic                     rd_en,
  output logic [AXON_W-1:0]        rd_axon,
  output logic                     rd_valid,
  output logic                     empty,
  input  logic                     proc_done,
  output logic                     core_done,
  output logic [TICK_W-1:0]        cur_tick,
  output logic [2:0]               error
`ifdef AXQ_STATS_EN
  ,
  output logic [15:0]              drop_full_cnt,
  output logic [15:0]              drop_late_cnt
`endif
);

  localparam int PTR_W  = $clog2(BANK_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OC_W   = $clog2(OUTSTANDING_MAX + 1);
  localparam int ADDR_W = TICK_W + PTR_W;

  logic [AXON_W-1:0] wr_axon;
  logic [TICK_W-1:0] wr_off, wr_bank;

  logic [NUM_TICKS-1:0]            push, pop, flush, b_full, b_empty;
  logic [NUM_TICKS-1:0][PTR_W-1:0] b_wptr, b_rptr;
  logic [NUM_TICKS-1:0][CNT_W-1:0] b_cnt;

  logic [OC_W-1:0]  outst, outst_nxt;
  logic [CNT_W-1:0] cur_cnt_nxt;
  logic rd_acc, wr_late, wr_acc, wr_ovf, tick_late, unf;

  axq_state_e state, state_nxt;

  assign wr_axon = wr_packet[AXON_W+TICK_W-1:TICK_W];
  assign wr_off  = wr_packet[TICK_W-1:0];
  // Ring arithmetic: TICK_W-bit sum wraps modulo NUM_TICKS.
  assign wr_bank = cur_tick + wr_off;

  assign empty = b_empty[cur_tick];
  assign full  = b_full[wr_bank];

  // Reads are refused on a tick edge and while the outstanding window is full.
  assign rd_acc    = rd_en && !empty && !tick && (outst != OC_W'(OUTSTANDING_MAX));
  // Offset-0 write racing a tick would land in the bank being flushed.
  assign wr_late   = wr_en && tick && (wr_bank == cur_tick);
  // A full bank still takes the write when its head pops in the same cycle.
  assign wr_acc    = wr_en && !wr_late &&
                     (!b_full[wr_bank] || (rd_acc && (wr_bank == cur_tick)));
  assign wr_ovf    = wr_en && !wr_late && !wr_acc;
  assign tick_late = tick && (!empty || (outst != '0));
  assign unf       = proc_done && (outst == '0);

  for (genvar g = 0; g < NUM_TICKS; g++) begin : g_bank
    assign push[g]  = wr_acc && (wr_bank  == TICK_W'(g));
    assign pop[g]   = rd_acc && (cur_tick == TICK_W'(g));
    assign flush[g] = tick   && (cur_tick == TICK_W'(g));

    tick_bank_ring #(.DEPTH(BANK_DEPTH)) u_ring (
      .clk    (clk),
      .rst    (rst),
      .push   (push[g]),
      .pop    (pop[g]),
      .flush  (flush[g]),
      .wr_ptr (b_wptr[g]),
      .rd_ptr (b_rptr[g]),
      .count  (b_cnt[g]),
      .full   (b_full[g]),
      .empty  (b_empty[g])
    );
  end

  // Shared spike storage, addressed {bank, ptr}.
  logic [AXON_W-1:0] mem [NUM_TICKS*BANK_DEPTH];
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_addr = {wr_bank,  b_wptr[wr_bank]};
  assign rd_addr = {cur_tick, b_rptr[cur_tick]};

  // Storage write port; no reset needed, occupancy is tracked by the rings.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= wr_axon;
  end

  // Registered read port; read-before-write covers full-bank push+pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_axon  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_axon <= mem[rd_addr];
    end
  end

  // Outstanding work: +1 per accepted read, -1 per proc_done, floor at 0.
  always_comb begin
    outst_nxt = outst;
    if (rd_acc && !proc_done)
      outst_nxt = outst + OC_W'(1);
    else if (proc_done && !rd_acc && (outst != '0))
      outst_nxt = outst - OC_W'(1);
  end

  // Outstanding register; a tick abandons whatever is still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       outst <= '0;
    else if (tick) outst <= '0;
    else           outst <= outst_nxt;
  end

  // Current tick index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cur_tick <= '0;
    else if (tick) cur_tick <= cur_tick + TICK_W'(1);
  end

  // Sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= '0;
    end else begin
      if (wr_ovf)                error[ERR_OVF]  <= 1'b1;
      if (tick_late || wr_late)  error[ERR_LATE] <= 1'b1;
      if (unf)                   error[ERR_UNF]  <= 1'b1;
    end
  end

  // Occupancy of the current bank after this edge (no tick case).
  always_comb begin
    cur_cnt_nxt = b_cnt[cur_tick];
    if (push[cur_tick] && !pop[cur_tick])
      cur_cnt_nxt = b_cnt[cur_tick] + CNT_W'(1);
    else if (pop[cur_tick] && !push[cur_tick])
      cur_cnt_nxt = b_cnt[cur_tick] - CNT_W'(1);
  end

  // Completion FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion FSM next state, driven from post-edge occupancy/outstanding.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (cur_cnt_nxt != '0)     state_nxt = SERVE;
          else if (outst_nxt != '0)  state_nxt = DRAIN;
        end
        SERVE: begin
          if (cur_cnt_nxt == '0)
            state_nxt = (outst_nxt != '0) ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (cur_cnt_nxt != '0)     state_nxt = SERVE;
          else if (outst_nxt == '0)  state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Right after a tick the FSM is IDLE for a cycle; gating with empty makes
  // core_done follow the new bank immediately.
  assign core_done = (state == IDLE) && empty;

`ifdef AXQ_STATS_EN
  logic [CNT_W:0] late_inc;
  logic [16:0]    late_sum;

  assign late_inc = (tick ? {1'b0, b_cnt[cur_tick]} : '0) + {{CNT_W{1'b0}}, wr_late};
  assign late_sum = {1'b0, drop_late_cnt} + 17'(late_inc);

  // Saturating drop statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_full_cnt <= '0;
      drop_late_cnt <= '0;
    end else begin
      if (wr_ovf && (drop_full_cnt != 16'hFFFF))
        drop_full_cnt <= drop_full_cnt + 16'd1;
      drop_late_cnt <= late_sum[16] ? 16'hFFFF : late_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_tick_binned_axon_queue.sv
// Scoreboard bench for tick_binned_axon_queue (NUM_TICKS=16, BANK_DEPTH=8).
module tb_tick_binned_axon_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, tick = 1'b0, rd_en = 1'b0, proc_done = 1'b0;
  logic [11:0] wr_packet = '0;
  logic        full, rd_valid, empty, core_done;
  logic [7:0]  rd_axon;
  logic [3:0]  cur_tick;
  logic [2:0]  error;
`ifdef AXQ_STATS_EN
  logic [15:0] drop_full_cnt, drop_late_cnt;
`endif

  int n_chk = 0, n_err = 0, n_vld = 0, base = 0;
  int sb[$];
  logic [31:0] exp_ax;

  always #5 clk = ~clk;

  tick_binned_axon_queue #(
    .NUM_AXONS(256), .NUM_TICKS(16), .BANK_DEPTH(8), .OUTSTANDING_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_packet(wr_packet), .full(full),
    .tick(tick), .rd_en(rd_en), .rd_axon(rd_axon), .rd_valid(rd_valid),
    .empty(empty), .proc_done(proc_done), .core_done(core_done),
    .cur_tick(cur_tick), .error(error)
`ifdef AXQ_STATS_EN
    , .drop_full_cnt(drop_full_cnt), .drop_late_cnt(drop_late_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] axon, input logic [3:0] off);
    wr_packet = {axon, off};
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] exp);
    sb.push_back(int'(exp));
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic pd();
    proc_done = 1'b1;
    cyc();
    proc_done = 1'b0;
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  // Every rd_valid pulse must match the oldest expected axon.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      exp_ax = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hDEAD;
      chk("rd_axon", 32'(rd_axon), exp_ax);
      n_vld++;
    end
  end

  initial begin
    // Reset state
    repeat (2) cyc();
    chk("rst_rd_valid",  32'(rd_valid),  0);
    chk("rst_rd_axon",   32'(rd_axon),   0);
    chk("rst_empty",     32'(empty),     1);
    chk("rst_core_done", 32'(core_done), 1);
    chk("rst_cur_tick",  32'(cur_tick),  0);
    chk("rst_error",     32'(error),     0);
    chk("rst_full",      32'(full),      0);
    rst = 1'b0;
    cyc();

    // Offset-0 write, read, proc_done
    wr(8'h2A, 4'd0);
    chk("t1_empty",     32'(empty),     0);
    chk("t1_core_busy", 32'(core_done), 0);
    rd(8'h2A);
    chk("t1_rd_valid",  32'(rd_valid),  1);
    chk("t1_rd_axon",   32'(rd_axon),   32'h2A);
    chk("t1_drain",     32'(core_done), 0);
    cyc();
    chk("t1_vld_pulse", 32'(rd_valid),  0);
    pd();
    chk("t1_core_done", 32'(core_done), 1);
    chk("t1_error",     32'(error),     0);

    // Offset 3: invisible until the third tick
    wr(8'h05, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_empty_wait", 32'(empty),    1);
      chk("t2_tick_idx",   32'(cur_tick), 32'(i));
      tk();
    end
    chk("t2_cur_tick", 32'(cur_tick), 3);
    chk("t2_empty",    32'(empty),    0);
    rd(8'h05);
    pd();
    chk("t2_core_done", 32'(core_done), 1);

    // Overflow: 9 writes into bank 5, 8 survive in order
    for (int i = 0; i < 8; i++) wr(8'(8'h10 + i), 4'd2);
    wr_packet = {8'h18, 4'd2};
    #1;
    chk("t3_full", 32'(full), 1);
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
    chk("t3_ovf_err", 32'(error), 3'b001);
`ifdef AXQ_STATS_EN
    chk("t3_drop_full", 32'(drop_full_cnt), 1);
`endif
    tk();
    tk();
    chk("t3_cur_tick", 32'(cur_tick), 5);
    for (int i = 0; i < 8; i++) sb.push_back(8'h10 + i);
    base = n_vld;
    rd_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      proc_done = (i != 0);
      cyc();
    end
    rd_en = 1'b0;
    proc_done = 1'b0;
    cyc();
    chk("t3_burst_cnt",  32'(n_vld - base), 8);
    chk("t3_empty",      32'(empty),        1);
    chk("t3_core_done",  32'(core_done),    1);
    chk("t3_err_sticky", 32'(error),        3'b001);

    // Wrap: offset 2 from tick 15 lands on tick 1
    repeat (10) tk();
    chk("t4_cur_tick15", 32'(cur_tick), 15);
    wr(8'h77, 4'd2);
    tk();
    chk("t4_empty_t0", 32'(empty), 1);
    tk();
    chk("t4_cur_tick1", 32'(cur_tick), 1);
    chk("t4_empty_t1",  32'(empty),    0);
    rd(8'h77);
    pd();

    // Outstanding limit: fifth read held off until proc_done arrives
    for (int i = 0; i < 5; i++) wr(8'(8'h30 + i), 4'd0);
    for (int i = 0; i < 4; i++) sb.push_back(8'h30 + i);
    base = n_vld;
    rd_en = 1'b1;
    repeat (5) cyc();
    rd_en = 1'b0;
    cyc();
    chk("t5_omax_reads", 32'(n_vld - base), 4);
    chk("t5_omax_empty", 32'(empty),        0);
    repeat (4) pd();
    rd(8'h34);
    pd();
    chk("t5_core_done", 32'(core_done), 1);
    chk("t5_error",     32'(error),     3'b001);

    // Late: tick with a spike still outstanding
    wr(8'h55, 4'd0);
    rd(8'h55);
    cyc();
    tk();
    chk("t6_late_err",  32'(error),     3'b011);
    chk("t6_cur_tick",  32'(cur_tick),  2);
    chk("t6_core_done", 32'(core_done), 1);
    // Outstanding was cleared, so this proc_done underflows
    pd();
    chk("t6_unf_err",   32'(error),     3'b111);

    repeat (2) cyc();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
